// File: rtl/param_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : param_memory_ctrl
// Brief    : Single-port data memory: valid/ready requests, byte strobes,
//            fixed-latency responses, address error flagging, post-reset clear.
// Revision : 1.0 - initial release
// ============================================================================
module param_memory_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 64,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic                    rsp_is_read,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    init_done
);

    localparam int c_BYTES     = DATA_WIDTH / 8;
    localparam int c_BYTE_BITS = $clog2(c_BYTES);
    localparam int c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [c_IDX_W-1:0]    r_clearIdx;
    logic                  r_initDone;
    logic                  w_lastClear;
    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_range;
    logic                  w_error;
    logic [ADDR_WIDTH-1:0] w_wordAddr;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_rdWord;

    logic [DATA_WIDTH-1:0] r_mem    [DEPTH];
    logic                  r_pValid [READ_LATENCY];
    logic                  r_pRead  [READ_LATENCY];
    logic                  r_pErr   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_pData  [READ_LATENCY];

    assign w_lastClear = (r_clearIdx == c_IDX_W'(DEPTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        req_ready   = 1'b0;
        case (r_state)
            ST_INIT:  if (w_lastClear) w_stateNext = ST_READY;
            ST_READY: req_ready = 1'b1;
            default:  w_stateNext = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clearIdx <= '0;
            r_initDone <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_clearIdx <= w_lastClear ? '0 : r_clearIdx + 1'b1;
            end
            r_initDone <= (r_state == ST_READY);
        end
    end

    assign init_done = r_initDone;

    // Byte-addressed port onto a word array; low bits must be zero.
    assign w_wordAddr = req_addr >> c_BYTE_BITS;
    assign w_idx      = w_wordAddr[c_IDX_W-1:0];
    assign w_range    = ({1'b0, w_wordAddr} >= (ADDR_WIDTH + 1)'(DEPTH));

    generate
        if (c_BYTE_BITS > 0) begin : g_alignCheck
            assign w_misaligned = |req_addr[c_BYTE_BITS-1:0];
        end else begin : g_noAlignCheck
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign w_error  = w_misaligned | w_range;
    assign w_accept = req_valid & req_ready;
    assign w_rdWord = r_mem[w_idx];

    // Array is not reset: the INIT sweep establishes its contents.
    always_ff @(posedge clock) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clearIdx] <= INIT_VALUE;
        end else if (w_accept && req_write && !w_error) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (req_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response shift pipeline; idle slots carry all-zero payloads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pValid[i] <= 1'b0;
                r_pRead[i]  <= 1'b0;
                r_pErr[i]   <= 1'b0;
                r_pData[i]  <= '0;
            end
        end else begin
            r_pValid[0] <= w_accept;
            r_pRead[0]  <= w_accept & ~req_write;
            r_pErr[0]   <= w_accept & w_error;
            r_pData[0]  <= (w_accept && !req_write && !w_error) ? w_rdWord : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pValid[i] <= r_pValid[i-1];
                r_pRead[i]  <= r_pRead[i-1];
                r_pErr[i]   <= r_pErr[i-1];
                r_pData[i]  <= r_pData[i-1];
            end
        end
    end

    assign rsp_valid   = r_pValid[READ_LATENCY-1];
    assign rsp_is_read = r_pRead[READ_LATENCY-1];
    assign rsp_error   = r_pErr[READ_LATENCY-1];
    assign rsp_rdata   = r_pData[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_param_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_memory_ctrl
// Brief    : Directed self-checking bench for param_memory_ctrl (latency 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_memory_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        reset3_n;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;

    logic        req_ready,  rsp_valid,  rsp_is_read,  rsp_error,  init_done;
    logic [31:0] rsp_rdata;
    logic        req3_ready, rsp3_valid, rsp3_is_read, rsp3_error, init3_done;
    logic [31:0] rsp3_rdata;

    int          nAsserts = 0;
    int          nFail    = 0;
    logic [34:0] model [3];

    always #5 clock = ~clock;

    param_memory_ctrl #(
        .DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(8), .READ_LATENCY(1), .INIT_VALUE(32'h0)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_is_read(rsp_is_read), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .init_done(init_done)
    );

    param_memory_ctrl #(
        .DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(8), .READ_LATENCY(3), .INIT_VALUE(32'h5A5A5A5A)
    ) dut3 (
        .clock(clock), .reset_n(reset3_n),
        .req_valid(req_valid), .req_ready(req3_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp3_valid), .rsp_is_read(rsp3_is_read), .rsp_rdata(rsp3_rdata),
        .rsp_error(rsp3_error), .init_done(init3_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {valid, is_read, error, rdata}
    task automatic chkRsp(input string tag, input logic v, input logic rd, input logic err,
                          input logic [31:0] data);
        chk(tag, {29'd0, rsp_valid, rsp_is_read, rsp_error, rsp_rdata}, {29'd0, v, rd, err, data});
    endtask

    task automatic step(input logic v, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        @(negedge clock);
    endtask

    // Latency-3 expectation: the response for a request shows two steps later.
    task automatic step3(input string tag, input logic v, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [34:0] expRsp);
        model[2] = model[1];
        model[1] = model[0];
        model[0] = v ? expRsp : 35'd0;
        step(v, w, a, d, 4'hF);
        chk(tag, {29'd0, rsp3_valid, rsp3_is_read, rsp3_error, rsp3_rdata}, {29'd0, model[2]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset_n   = 1'b0;
        reset3_n  = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h10;
        req_wdata = 32'h0;
        req_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) model[i] = 35'd0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {req_ready, rsp_valid, rsp_is_read, rsp_error, init_done, rsp_rdata}, 64'd0);

        // Clear sequence with a read already waiting
        reset_n = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        chk("init_ready_low_cycles", 64'(cnt), 64'd64);
        chk("init_done_lags_ready", {63'd0, init_done}, 64'd0);
        @(negedge clock);
        chk("init_done_high", {63'd0, init_done}, 64'd1);
        chkRsp("read_after_init", 1'b1, 1'b1, 1'b0, 32'h0);

        // Back-to-back writes then reads, one response per cycle
        step(1, 1, 8'h04, 32'h2, 4'hF); chkRsp("wr_04", 1, 0, 0, 32'h0);
        step(1, 1, 8'h08, 32'h5, 4'hF); chkRsp("wr_08", 1, 0, 0, 32'h0);
        step(1, 1, 8'h0C, 32'h9, 4'hF); chkRsp("wr_0c", 1, 0, 0, 32'h0);
        step(1, 1, 8'h18, 32'h7, 4'hF); chkRsp("wr_18", 1, 0, 0, 32'h0);
        step(1, 1, 8'h1C, 32'hA, 4'hF); chkRsp("wr_1c", 1, 0, 0, 32'h0);
        step(1, 0, 8'h18, 32'h0, 4'hF); chkRsp("rd_18", 1, 1, 0, 32'h7);
        step(1, 0, 8'h04, 32'h0, 4'hF); chkRsp("rd_04", 1, 1, 0, 32'h2);
        step(1, 0, 8'h1C, 32'h0, 4'hF); chkRsp("rd_1c", 1, 1, 0, 32'hA);
        step(1, 0, 8'h08, 32'h0, 4'hF); chkRsp("rd_08", 1, 1, 0, 32'h5);
        step(1, 0, 8'h0C, 32'h0, 4'hF); chkRsp("rd_0c", 1, 1, 0, 32'h9);
        step(0, 0, 8'h0C, 32'h0, 4'hF); chkRsp("idle_zero", 0, 0, 0, 32'h0);

        // Byte strobes
        step(1, 1, 8'h20, 32'hAABBCCDD, 4'hF); chkRsp("wr_20_full", 1, 0, 0, 32'h0);
        step(1, 1, 8'h20, 32'h11223344, 4'h5); chkRsp("wr_20_strb", 1, 0, 0, 32'h0);
        step(1, 0, 8'h20, 32'h0, 4'hF);        chkRsp("rd_20_merged", 1, 1, 0, 32'hAA22CC44);

        // Misalignment errors, zero-strobe write, last in-range word
        step(1, 0, 8'h06, 32'h0, 4'hF);        chkRsp("rd_misaligned", 1, 1, 1, 32'h0);
        step(1, 1, 8'h22, 32'hFFFFFFFF, 4'hF); chkRsp("wr_misaligned", 1, 0, 1, 32'h0);
        step(1, 0, 8'h20, 32'h0, 4'hF);        chkRsp("rd_20_unchanged", 1, 1, 0, 32'hAA22CC44);
        step(1, 1, 8'h20, 32'h12345678, 4'h0); chkRsp("wr_nostrobe", 1, 0, 0, 32'h0);
        step(1, 0, 8'h20, 32'h0, 4'hF);        chkRsp("rd_20_nostrobe", 1, 1, 0, 32'hAA22CC44);
        step(1, 1, 8'hFC, 32'h600DF00D, 4'hF); chkRsp("wr_last_word", 1, 0, 0, 32'h0);
        step(1, 0, 8'hFC, 32'h0, 4'hF);        chkRsp("rd_last_word", 1, 1, 0, 32'h600DF00D);

        // Read immediately after write to the same word
        step(1, 1, 8'h40, 32'hDEADBEEF, 4'hF); chkRsp("wr_40", 1, 0, 0, 32'h0);
        step(1, 0, 8'h40, 32'h0, 4'hF);        chkRsp("rd_40_fresh", 1, 1, 0, 32'hDEADBEEF);
        step(0, 0, 8'h00, 32'h0, 4'hF);        chkRsp("idle_end", 0, 0, 0, 32'h0);

        // Latency-3, DEPTH-32 instance
        reset3_n = 1'b1;
        cnt = 0;
        while (!req3_ready && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        chk("init3_ready_low_cycles", 64'(cnt), 64'd32);
        step3("l3_wr_00", 1, 1, 8'h00, 32'h100, {3'b100, 32'h0});
        step3("l3_wr_04", 1, 1, 8'h04, 32'h101, {3'b100, 32'h0});
        step3("l3_wr_08", 1, 1, 8'h08, 32'h102, {3'b100, 32'h0});
        step3("l3_rd_00", 1, 0, 8'h00, 32'h0,   {3'b110, 32'h100});
        step3("l3_rd_04", 1, 0, 8'h04, 32'h0,   {3'b110, 32'h101});
        step3("l3_rd_08", 1, 0, 8'h08, 32'h0,   {3'b110, 32'h102});
        step3("l3_rd_0c", 1, 0, 8'h0C, 32'h0,   {3'b110, 32'h5A5A5A5A});
        step3("l3_rd_7c", 1, 0, 8'h7C, 32'h0,   {3'b110, 32'h5A5A5A5A});
        step3("l3_rd_80", 1, 0, 8'h80, 32'h0,   {3'b111, 32'h0});
        step3("l3_wr_fc", 1, 1, 8'hFC, 32'h1,   {3'b101, 32'h0});
        step3("l3_drain0", 0, 0, 8'h00, 32'h0,  35'd0);
        step3("l3_drain1", 0, 0, 8'h00, 32'h0,  35'd0);
        step3("l3_drain2", 0, 0, 8'h00, 32'h0,  35'd0);
        step3("l3_rd_7c_kept", 1, 0, 8'h7C, 32'h0, {3'b110, 32'h5A5A5A5A});

        // Reset with reads in flight
        step3("l3_rd_00_b", 1, 0, 8'h00, 32'h0, {3'b110, 32'h100});
        step3("l3_rd_04_b", 1, 0, 8'h04, 32'h0, {3'b110, 32'h101});
        reset3_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("l3_reset_quiet", {58'd0, rsp3_valid, rsp3_is_read, rsp3_error, req3_ready, init3_done,
                                   |rsp3_rdata}, 64'd0);
        end
        req_valid = 1'b0;
        reset3_n  = 1'b1;
        cnt = 0;
        while (!req3_ready && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        chk("init3_restart_cycles", 64'(cnt), 64'd32);
        for (int i = 0; i < 3; i++) model[i] = 35'd0;
        step3("l3_rd_00_cleared", 1, 0, 8'h00, 32'h0, {3'b110, 32'h5A5A5A5A});
        step3("l3_tail0", 0, 0, 8'h00, 32'h0, 35'd0);
        step3("l3_tail1", 0, 0, 8'h00, 32'h0, 35'd0);
        step3("l3_tail2", 0, 0, 8'h00, 32'h0, 35'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
`default_nettype wire
